nanorv32_irq_flow_ctrl: RTL and testbench



---
 rtl/nanorv32_irq_flow_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_nanorv32_irq_flow_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/nanorv32_irq_flow_ctrl.sv
// nanorv32 pipeline flow control with prioritised multi-line interrupt entry.
// Produces stall / new-PC / data-cycle strobes and sequences the micro-ROM
// address that replaces fetched code during context save (entry) and restore
// (reti exit).
module nanorv32_irq_flow_ctrl #(
   parameter int NUM_IRQ     = 4,
   parameter int UROM_AW     = 6,
   parameter int ENTRY_START = 0,
   parameter int ENTRY_STOP  = 15,
   parameter int EXIT_START  = 16,
   parameter int EXIT_STOP   = 31,
   localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               branch_taken,
   input  logic               datamem_read,
   input  logic               datamem_write,
   input  logic               hreadyd,
   input  logic               codeif_cpu_ready_r,
   input  logic               interlock,
   input  logic               branch_wait,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               reti_inst_detected,
   output logic               force_stall_pstate,
   output logic               force_stall_pstate2,
   output logic               force_stall_reset,
   output logic               output_new_pc,
   output logic               valid_inst,
   output logic               data_access_cycle,
   output logic [1:0]         pstate_r,
   output logic [UROM_AW-1:0] urom_addr_r,
   output logic               irq_bypass_inst_reg_r,
   output logic               interrupt_state_r,
   output logic               allow_hidden_use_of_x0,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic [IW-1:0]      irq_id_r
);

   typedef enum logic [1:0] {
      PS_RESET  = 2'd0,
      PS_CONT   = 2'd1,
      PS_BRANCH = 2'd2,
      PS_WAITLD = 2'd3
   } pstate_t;

   localparam logic [UROM_AW-1:0] ENTRY_START_A = UROM_AW'(ENTRY_START);
   localparam logic [UROM_AW-1:0] ENTRY_STOP_A  = UROM_AW'(ENTRY_STOP);
   localparam logic [UROM_AW-1:0] EXIT_START_A  = UROM_AW'(EXIT_START);
   localparam logic [UROM_AW-1:0] EXIT_STOP_A   = UROM_AW'(EXIT_STOP);

   pstate_t              pstate_q, pstate_d;
   logic [UROM_AW-1:0]   urom_q, urom_d;
   logic                 bypass_q, bypass_d;
   logic                 int_state_q, int_state_d;
   logic                 restore_q, restore_d;
   logic [IW-1:0]        id_q, id_d;
   logic [NUM_IRQ-1:0]   ack_q, ack_d;

   logic                 freeze;
   logic                 data_acc;
   logic [NUM_IRQ-1:0]   req;
   logic [IW-1:0]        win_id;
   logic [NUM_IRQ-1:0]   win_oh;
   logic                 cont_like;
   logic                 advance;
   logic                 accept;
   logic [UROM_AW-1:0]   stop_addr;

   assign freeze    = interlock | branch_wait;
   assign data_acc  = datamem_read | datamem_write;
   assign req       = irq & irq_mask;
   assign stop_addr = restore_q ? EXIT_STOP_A : ENTRY_STOP_A;

   // Fixed-priority encoder: scanning downwards leaves the lowest set index.
   always_comb begin
      win_id = '0;
      win_oh = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_id    = IW'(i);
            win_oh    = '0;
            win_oh[i] = 1'b1;
         end
      end
   end

   // Strobes and next-state decode; a freeze overrides every state update.
   always_comb begin
      force_stall_pstate  = 1'b0;
      force_stall_pstate2 = 1'b0;
      force_stall_reset   = 1'b0;
      output_new_pc       = 1'b0;
      data_access_cycle   = 1'b0;
      pstate_d            = pstate_q;
      urom_d              = urom_q;
      bypass_d            = bypass_q;
      int_state_d         = int_state_q;
      restore_d           = restore_q;
      id_d                = id_q;
      ack_d               = '0;
      cont_like           = 1'b0;
      advance             = 1'b0;
      accept              = 1'b0;

      case (pstate_q)
         PS_RESET: begin
            force_stall_pstate  = 1'b1;
            force_stall_pstate2 = 1'b1;
            force_stall_reset   = 1'b1;
            pstate_d            = PS_CONT;
         end
         PS_CONT: begin
            cont_like = 1'b1;
         end
         PS_BRANCH: begin
            output_new_pc = 1'b1;
            if (reti_inst_detected && int_state_q) begin
               // Return from handler: run the restore sequence from micro-ROM.
               urom_d      = EXIT_START_A;
               bypass_d    = 1'b1;
               restore_d   = 1'b1;
               int_state_d = 1'b0;
               pstate_d    = PS_CONT;
            end else if (codeif_cpu_ready_r) begin
               pstate_d  = PS_CONT;
               bypass_d  = 1'b0;
               restore_d = 1'b0;
            end else begin
               force_stall_pstate = 1'b1;
            end
         end
         default: begin
            // WAITLD is only reachable through the legacy encoding.
            if (hreadyd) begin
               cont_like = 1'b1;
               pstate_d  = PS_CONT;
            end else begin
               force_stall_pstate  = 1'b1;
               force_stall_pstate2 = 1'b1;
            end
         end
      endcase

      if (cont_like) begin
         if (branch_taken) begin
            force_stall_pstate = 1'b1;
            output_new_pc      = 1'b1;
            pstate_d           = PS_BRANCH;
         end else begin
            advance = ~data_acc | hreadyd;
            if (data_acc) begin
               data_access_cycle   = 1'b1;
               force_stall_pstate  = ~hreadyd;
               force_stall_pstate2 = 1'b1;
            end else if ((req != '0) && !bypass_q && !int_state_q) begin
               accept = 1'b1;
            end
         end
      end

      if (advance && bypass_q && (urom_q != stop_addr))
         urom_d = urom_q + 1'b1;

      if (accept) begin
         urom_d      = ENTRY_START_A;
         bypass_d    = 1'b1;
         int_state_d = 1'b1;
         id_d        = win_id;
         ack_d       = win_oh;
      end

      if (freeze) begin
         pstate_d    = pstate_q;
         urom_d      = urom_q;
         bypass_d    = bypass_q;
         int_state_d = int_state_q;
         restore_d   = restore_q;
         id_d        = id_q;
         ack_d       = '0;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pstate_q    <= PS_RESET;
         urom_q      <= '0;
         bypass_q    <= 1'b0;
         int_state_q <= 1'b0;
         restore_q   <= 1'b0;
         id_q        <= '0;
         ack_q       <= '0;
      end else begin
         pstate_q    <= pstate_d;
         urom_q      <= urom_d;
         bypass_q    <= bypass_d;
         int_state_q <= int_state_d;
         restore_q   <= restore_d;
         id_q        <= id_d;
         ack_q       <= ack_d;
      end
   end

   assign valid_inst             = 1'b1;
   assign pstate_r               = pstate_q;
   assign urom_addr_r            = urom_q;
   assign irq_bypass_inst_reg_r  = bypass_q;
   assign interrupt_state_r      = int_state_q;
   assign allow_hidden_use_of_x0 = restore_q;
   assign irq_id_r               = id_q;
   // The acknowledge pulse is suppressed in any frozen cycle.
   assign irq_ack                = ack_q & {NUM_IRQ{~freeze}};

endmodule

// File: tb/tb_nanorv32_irq_flow_ctrl.sv
// Vector bench for nanorv32_irq_flow_ctrl: each record drives one cycle of
// inputs and names the outputs expected in that same cycle.
module tb_nanorv32_irq_flow_ctrl;

   // ctl bit positions: {bt, dr, dw, hr, rdy, il, bw, reti}
   localparam logic [7:0] BT = 8'h80, DR = 8'h40, HR = 8'h10, RDY = 8'h08,
                          IL = 8'h04, BW = 8'h02, RETI = 8'h01, NONE = 8'h00;
   // strobe bits: {fsp, fsp2, fsr, npc, dac}
   localparam logic [4:0] S_FSP = 5'h10, S_FSP2 = 5'h08, S_FSR = 5'h04,
                          S_NPC = 5'h02, S_DAC = 5'h01, S_RST = 5'h1C, S_0 = 5'h00;
   // flag bits: {bypass, interrupt_state, restore}
   localparam logic [2:0] F_BI = 3'b110, F_BR = 3'b101, F_I = 3'b010, F_0 = 3'b000;

   typedef struct {
      string      name;
      logic       rstn;
      logic [7:0] ctl;
      logic [3:0] irq;
      logic [3:0] mask;
      logic [1:0] ps;
      logic [5:0] ua;
      logic [2:0] fl;
      logic [3:0] ack;
      logic [1:0] id;
      logic [4:0] st;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       branch_taken = 1'b0, datamem_read = 1'b0, datamem_write = 1'b0;
   logic       hreadyd = 1'b0, codeif_cpu_ready_r = 1'b0;
   logic       interlock = 1'b0, branch_wait = 1'b0, reti_inst_detected = 1'b0;
   logic [3:0] irq = '0, irq_mask = '0;
   logic       force_stall_pstate, force_stall_pstate2, force_stall_reset;
   logic       output_new_pc, valid_inst, data_access_cycle;
   logic [1:0] pstate_r;
   logic [5:0] urom_addr_r;
   logic       irq_bypass_inst_reg_r, interrupt_state_r, allow_hidden_use_of_x0;
   logic [3:0] irq_ack;
   logic [1:0] irq_id_r;

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t sb[$];
   vec_t tbl[$];

   nanorv32_irq_flow_ctrl dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .branch_taken           (branch_taken),
      .datamem_read           (datamem_read),
      .datamem_write          (datamem_write),
      .hreadyd                (hreadyd),
      .codeif_cpu_ready_r     (codeif_cpu_ready_r),
      .interlock              (interlock),
      .branch_wait            (branch_wait),
      .irq                    (irq),
      .irq_mask               (irq_mask),
      .reti_inst_detected     (reti_inst_detected),
      .force_stall_pstate     (force_stall_pstate),
      .force_stall_pstate2    (force_stall_pstate2),
      .force_stall_reset      (force_stall_reset),
      .output_new_pc          (output_new_pc),
      .valid_inst             (valid_inst),
      .data_access_cycle      (data_access_cycle),
      .pstate_r               (pstate_r),
      .urom_addr_r            (urom_addr_r),
      .irq_bypass_inst_reg_r  (irq_bypass_inst_reg_r),
      .interrupt_state_r      (interrupt_state_r),
      .allow_hidden_use_of_x0 (allow_hidden_use_of_x0),
      .irq_ack                (irq_ack),
      .irq_id_r               (irq_id_r)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input string name, input logic rstn, input logic [7:0] ctl,
                               input logic [3:0] irqv, input logic [3:0] mask,
                               input logic [1:0] ps, input logic [5:0] ua, input logic [2:0] fl,
                               input logic [3:0] ack, input logic [1:0] id, input logic [4:0] st);
      vec_t v;
      v.name = name; v.rstn = rstn; v.ctl = ctl; v.irq = irqv; v.mask = mask;
      v.ps = ps; v.ua = ua; v.fl = fl; v.ack = ack; v.id = id; v.st = st;
      return v;
   endfunction

   // Drive one cycle's inputs at the falling edge, queue the expectation,
   // then sample the DUT mid-phase and score it against the queue head.
   task automatic apply(input vec_t v);
      vec_t        e;
      logic [22:0] act, exp_v;
      @(negedge clk);
      rst_n = v.rstn;
      {branch_taken, datamem_read, datamem_write, hreadyd,
       codeif_cpu_ready_r, interlock, branch_wait, reti_inst_detected} = v.ctl;
      irq      = v.irq;
      irq_mask = v.mask;
      sb.push_back(v);
      #2;
      e = sb.pop_front();
      act = {pstate_r, urom_addr_r, irq_bypass_inst_reg_r, interrupt_state_r,
             allow_hidden_use_of_x0, irq_ack, irq_id_r, force_stall_pstate,
             force_stall_pstate2, force_stall_reset, output_new_pc,
             data_access_cycle, valid_inst};
      exp_v = {e.ps, e.ua, e.fl, e.ack, e.id, e.st, 1'b1};
      n_vec++;
      if (act !== exp_v)
         begin
            n_bad++;
            $display("FAIL %s: got ps=%0d ua=%0d fl=%b ack=%b id=%0d st=%b vi=%b, want ps=%0d ua=%0d fl=%b ack=%b id=%0d st=%b vi=1",
                     e.name, act[22:21], act[20:15], act[14:12], act[11:8], act[7:6], act[5:1], act[0],
                     e.ps, e.ua, e.fl, e.ack, e.id, e.st);
         end
      else
         $display("ok   %s: ps=%0d ua=%0d fl=%b ack=%b id=%0d st=%b",
                  e.name, e.ps, e.ua, e.fl, e.ack, e.id, e.st);
   endtask

   initial begin
      // Reset release, idle, then an IRQ entry with load stalls and an interlock.
      tbl.push_back(mk("rst_hold", 0, NONE, 4'h0, 4'hF, 0, 0, F_0, 4'h0, 0, S_RST));
      tbl.push_back(mk("rst_rel",  1, NONE, 4'h0, 4'hF, 0, 0, F_0, 4'h0, 0, S_RST));
      tbl.push_back(mk("idle0",    1, NONE, 4'h0, 4'hF, 1, 0, F_0, 4'h0, 0, S_0));
      tbl.push_back(mk("idle1",    1, NONE, 4'h0, 4'hF, 1, 0, F_0, 4'h0, 0, S_0));
      tbl.push_back(mk("irq_req",  1, NONE, 4'h6, 4'hF, 1, 0, F_0, 4'h0, 0, S_0));
      tbl.push_back(mk("irq_ack",  1, NONE, 4'h0, 4'hF, 1, 0, F_BI, 4'h2, 1, S_0));
      tbl.push_back(mk("cnt1",     1, NONE, 4'h0, 4'hF, 1, 1, F_BI, 4'h0, 1, S_0));
      tbl.push_back(mk("cnt2",     1, NONE, 4'h0, 4'hF, 1, 2, F_BI, 4'h0, 1, S_0));
      tbl.push_back(mk("ld_wait",  1, DR,   4'h0, 4'hF, 1, 3, F_BI, 4'h0, 1, S_FSP | S_FSP2 | S_DAC));
      tbl.push_back(mk("ld_rdy",   1, DR | HR, 4'h0, 4'hF, 1, 3, F_BI, 4'h0, 1, S_FSP2 | S_DAC));
      tbl.push_back(mk("cnt4",     1, NONE, 4'h0, 4'hF, 1, 4, F_BI, 4'h0, 1, S_0));
      tbl.push_back(mk("il1",      1, IL,   4'h0, 4'hF, 1, 5, F_BI, 4'h0, 1, S_0));
      tbl.push_back(mk("il2",      1, IL,   4'h0, 4'hF, 1, 5, F_BI, 4'h0, 1, S_0));
      tbl.push_back(mk("il3",      1, IL,   4'h0, 4'hF, 1, 5, F_BI, 4'h0, 1, S_0));
      tbl.push_back(mk("resume",   1, NONE, 4'h0, 4'hF, 1, 5, F_BI, 4'h0, 1, S_0));
      tbl.push_back(mk("cnt6",     1, NONE, 4'h0, 4'hF, 1, 6, F_BI, 4'h0, 1, S_0));
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Counting to saturation with a new request pending inside the handler.
      for (int k = 7; k <= 17; k++)
         apply(mk("sat", 1, NONE, 4'h1, 4'hF, 1, 6'((k > 15) ? 15 : k), F_BI, 4'h0, 1, S_0));

      // Entry jump, handler, reti, exit sequence, then a masked request.
      apply(mk("jmp",      1, BT,         4'h0, 4'hF, 1, 15, F_BI, 4'h0, 1, S_FSP | S_NPC));
      apply(mk("br_wait",  1, NONE,       4'h0, 4'hF, 2, 15, F_BI, 4'h0, 1, S_FSP | S_NPC));
      apply(mk("br_done",  1, RDY,        4'h0, 4'hF, 2, 15, F_BI, 4'h0, 1, S_NPC));
      apply(mk("handler",  1, NONE,       4'h0, 4'hF, 1, 15, F_I,  4'h0, 1, S_0));
      apply(mk("h_br",     1, BT,         4'h0, 4'hF, 1, 15, F_I,  4'h0, 1, S_FSP | S_NPC));
      apply(mk("reti",     1, RETI | RDY, 4'h0, 4'hF, 2, 15, F_I,  4'h0, 1, S_NPC));
      apply(mk("exit0",    1, NONE,       4'h0, 4'hF, 1, 16, F_BR, 4'h0, 1, S_0));
      apply(mk("exit1",    1, NONE,       4'h0, 4'hF, 1, 17, F_BR, 4'h0, 1, S_0));
      apply(mk("x_jmp",    1, BT,         4'h0, 4'hF, 1, 18, F_BR, 4'h0, 1, S_FSP | S_NPC));
      apply(mk("x_done",   1, RDY,        4'h0, 4'hF, 2, 18, F_BR, 4'h0, 1, S_NPC));
      apply(mk("masked",   1, NONE,       4'h1, 4'hE, 1, 18, F_0,  4'h0, 1, S_0));
      apply(mk("masked2",  1, NONE,       4'h1, 4'hE, 1, 18, F_0,  4'h0, 1, S_0));

      // Branch wins over a simultaneous IRQ; acceptance after the branch.
      apply(mk("br_irq",   1, BT,   4'h8, 4'hF, 1, 18, F_0,  4'h0, 1, S_FSP | S_NPC));
      apply(mk("br_irq_w", 1, NONE, 4'h8, 4'hF, 2, 18, F_0,  4'h0, 1, S_FSP | S_NPC));
      apply(mk("br_irq_r", 1, RDY,  4'h8, 4'hF, 2, 18, F_0,  4'h0, 1, S_NPC));
      apply(mk("acc3",     1, NONE, 4'h8, 4'hF, 1, 18, F_0,  4'h0, 1, S_0));
      apply(mk("ack3",     1, NONE, 4'h0, 4'hF, 1, 0,  F_BI, 4'h8, 3, S_0));
      apply(mk("e1",       1, NONE, 4'h0, 4'hF, 1, 1,  F_BI, 4'h0, 3, S_0));
      apply(mk("e2",       1, BT,   4'h0, 4'hF, 1, 2,  F_BI, 4'h0, 3, S_FSP | S_NPC));
      apply(mk("e_reti",   1, RETI, 4'h0, 4'hF, 2, 2,  F_BI, 4'h0, 3, S_NPC));
      apply(mk("x0",       1, NONE, 4'h0, 4'hF, 1, 16, F_BR, 4'h0, 3, S_0));

      // Asynchronous reset in the middle of the exit sequence.
      apply(mk("rst_mid",  0, NONE, 4'h0, 4'hF, 0, 0, F_0, 4'h0, 0, S_RST));
      apply(mk("rel2",     1, NONE, 4'h0, 4'hF, 0, 0, F_0, 4'h0, 0, S_RST));
      apply(mk("idle3",    1, NONE, 4'h0, 4'hF, 1, 0, F_0, 4'h0, 0, S_0));

      // Priorities: branch over data, ordinary reti, data and freeze over IRQ.
      apply(mk("bt_dr",    1, BT | DR,    4'h0, 4'hF, 1, 0, F_0,  4'h0, 0, S_FSP | S_NPC));
      apply(mk("reti0",    1, RETI | RDY, 4'h0, 4'hF, 2, 0, F_0,  4'h0, 0, S_NPC));
      apply(mk("idle4",    1, NONE,       4'h0, 4'hF, 1, 0, F_0,  4'h0, 0, S_0));
      apply(mk("dr_irq",   1, DR | HR,    4'h2, 4'hF, 1, 0, F_0,  4'h0, 0, S_FSP2 | S_DAC));
      apply(mk("bw_irq",   1, BW,         4'h2, 4'hF, 1, 0, F_0,  4'h0, 0, S_0));
      apply(mk("acc1",     1, NONE,       4'h2, 4'hF, 1, 0, F_0,  4'h0, 0, S_0));
      apply(mk("ack1",     1, NONE,       4'h0, 4'hF, 1, 0, F_BI, 4'h2, 1, S_0));
      apply(mk("c1",       1, NONE,       4'h0, 4'hF, 1, 1, F_BI, 4'h0, 1, S_0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
